mem_lsu_unit: RTL

MEM_LSU_UNIT -- requirements
Module: mem_lsu_unit

---
 rtl/mem_lsu_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu_unit.sv
// Load/store unit: one outstanding access, posted stores, sign/zero-extended loads.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of issuing them.
module mem_lsu_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_in_load,
    input  logic                i_in_store,
    input  logic [2:0]          i_in_funct3,
    input  logic [ADDR_W-1:0]   i_in_addr,
    input  logic [XLEN-1:0]     i_in_store_data,
    input  logic [REG_AW-1:0]   i_in_rd_addr,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic                o_mem_req_write,
    output logic [ADDR_W-1:0]   o_mem_req_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_wstrb,
    input  logic                i_mem_rsp_valid,
    input  logic [XLEN-1:0]     i_mem_rdata,
    output logic                o_wb_valid,
    output logic [REG_AW-1:0]   o_wb_rd_addr,
    output logic [XLEN-1:0]     o_wb_data,
    output logic                o_exc_valid,
    output logic [3:0]          o_exc_cause,
    output logic [ADDR_W-1:0]   o_exc_tval,
    output logic                o_busy
);

    localparam int unsigned SW    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(SW);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_write;
    logic [XLEN-1:0]     r_wdata;
    logic [SW-1:0]       r_wstrb;
    logic [2:0]          r_funct3;
    logic [OFF_W-1:0]    r_offset;
    logic [REG_AW-1:0]   r_rd;
    logic                r_wb_valid;
    logic [REG_AW-1:0]   r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;
    logic                r_exc_valid;
    logic [3:0]          r_exc_cause;
    logic [ADDR_W-1:0]   r_exc_tval;

    logic                w_accept;
    logic                w_is_op;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_exc;
    logic                w_start;
    logic [OFF_W-1:0]    w_off;
    logic [SW-1:0]       w_ones;
    logic [SW-1:0]       w_wstrb;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_rsh;
    logic [XLEN-1:0]     w_ld_ext;
    logic [3:0]          w_cause;

    assign w_accept  = i_in_valid & o_in_ready;
    assign w_is_op   = i_in_load | i_in_store;
    assign w_off     = i_in_addr[OFF_W-1:0];
    assign w_illegal = (i_in_funct3 == 3'b111) ||
                       ((XLEN == 32) && ((i_in_funct3 == 3'b011) || (i_in_funct3 == 3'b110)));

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] w_size_m;

    always_comb begin
        w_size_m = 3'd0;
        case (i_in_funct3[1:0])
            2'b00:   w_size_m = 3'd0;
            2'b01:   w_size_m = 3'd1;
            2'b10:   w_size_m = 3'd3;
            default: w_size_m = 3'd7;
        endcase
    end

    assign w_misalign = |(w_off & OFF_W'(w_size_m));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_exc   = w_accept & w_is_op & (w_illegal | w_misalign);
    assign w_start = w_accept & w_is_op & ~w_illegal & ~w_misalign;
    assign w_cause = w_illegal ? 4'd2 : (i_in_load ? 4'd4 : 4'd6);

    always_comb begin
        w_ones = '0;
        case (i_in_funct3[1:0])
            2'b00:   w_ones = SW'(32'd1);
            2'b01:   w_ones = SW'(32'd3);
            2'b10:   w_ones = SW'(32'd15);
            default: w_ones = '1;
        endcase
    end

    // Lanes pushed past the top of the bus fall off the shift.
    assign w_wstrb = w_ones << w_off;
    assign w_wdata = i_in_store_data << {w_off, 3'b000};

    assign w_rsh = i_mem_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_ld_ext = w_rsh;
        case (r_funct3)
            3'b000:  w_ld_ext = XLEN'($signed(w_rsh[7:0]));
            3'b001:  w_ld_ext = XLEN'($signed(w_rsh[15:0]));
            3'b010:  w_ld_ext = XLEN'($signed(w_rsh[31:0]));
            3'b100:  w_ld_ext = XLEN'(w_rsh[7:0]);
            3'b101:  w_ld_ext = XLEN'(w_rsh[15:0]);
            3'b110:  w_ld_ext = XLEN'(w_rsh[31:0]);
            default: w_ld_ext = w_rsh;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_start) w_state_next = StReq;
            StReq:  if (i_mem_req_ready) w_state_next = r_write ? StIdle : StWait;
            StWait: if (i_mem_rsp_valid) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_addr  <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_funct3    <= '0;
            r_offset    <= '0;
            r_rd        <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
            r_exc_tval  <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            if (w_start) begin
                r_req_addr <= {i_in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_write    <= i_in_store & ~i_in_load;
                r_wdata    <= w_wdata;
                r_wstrb    <= w_wstrb;
                r_funct3   <= i_in_funct3;
                r_offset   <= w_off;
                r_rd       <= i_in_rd_addr;
            end
            if (w_exc) begin
                r_exc_valid <= 1'b1;
                r_exc_cause <= w_cause;
                r_exc_tval  <= i_in_addr;
            end
            // x0 destination: the read still happens, only the writeback is dropped.
            if ((r_state == StWait) && i_mem_rsp_valid) begin
                r_wb_valid <= |r_rd;
                r_wb_rd    <= r_rd;
                r_wb_data  <= w_ld_ext;
            end
        end
    end

    assign o_in_ready      = (r_state == StIdle);
    assign o_busy          = (r_state != StIdle);
    assign o_mem_req_valid = (r_state == StReq);
    assign o_mem_req_write = r_write;
    assign o_mem_req_addr  = r_req_addr;
    assign o_mem_wdata     = r_wdata;
    assign o_mem_wstrb     = r_wstrb;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_rd_addr    = r_wb_rd;
    assign o_wb_data       = r_wb_data;
    assign o_exc_valid     = r_exc_valid;
    assign o_exc_cause     = r_exc_cause;
    assign o_exc_tval      = r_exc_tval;

endmodule
